// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Arbitrates NUM_REQ writeback sources onto the single register-file
//            write port and tracks reserved-but-unwritten destinations.
//            Define RF_WB_RR_ARB_EN for round-robin; otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [XLEN*NUM_REQ-1:0] req_data,
    input  logic                    wb_stall,
    input  logic                    rsv_valid,
    input  logic [4:0]              rsv_rd,
    output logic                    reg_write,
    output logic [4:0]              rs3_adds,
    output logic [XLEN-1:0]         w_data,
    output logic [31:0]             pend_mask
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [4:0]         w_rd_arr   [NUM_REQ];
    logic [XLEN-1:0]    w_data_arr [NUM_REQ];

    logic               w_found;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_xfer;
    logic [4:0]         w_sel_rd;
    logic [XLEN-1:0]    w_sel_data;
    logic [31:0]        w_pend_nxt;

    logic               r_we;
    logic [4:0]         r_addr;
    logic [XLEN-1:0]    r_data;
    logic [31:0]        r_pend;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_rd_arr[gi]   = req_rd[5*gi +: 5];
            assign w_data_arr[gi] = req_data[XLEN*gi +: XLEN];
        end
    endgenerate

`ifdef RF_WB_RR_ARB_EN
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_REQ - 1);

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W:0]   w_sum;

    // Search begins one past the last winner and wraps, so every valid
    // requester is reached within NUM_REQ-1 foreign grants.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_IDX_W + 1)'(k);
            if (w_sum >= (c_IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_IDX_W + 1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[c_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_PTR_RST;
        end else if (w_xfer) begin
            r_ptr <= w_idx;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[k]) begin
                w_found = 1'b1;
                w_idx   = c_IDX_W'(k);
            end
        end
    end
`endif

    assign w_xfer     = w_found && !rst && !wb_stall;
    assign w_sel_rd   = w_rd_arr[w_idx];
    assign w_sel_data = w_data_arr[w_idx];

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_idx] = 1'b1;
        end
    end

    // Clear before set: a fresh reservation of the register being written
    // must survive the retiring write.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_xfer) begin
            w_pend_nxt[w_sel_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != 5'd0)) begin
            w_pend_nxt[rsv_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_pend <= '0;
        end else begin
            r_we   <= w_xfer && (w_sel_rd != 5'd0);
            r_pend <= w_pend_nxt;
            if (w_xfer) begin
                r_addr <= w_sel_rd;
                r_data <= w_sel_data;
            end
        end
    end

    assign reg_write = r_we;
    assign rs3_adds  = r_addr;
    assign w_data    = r_data;
    assign pend_mask = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed scoreboard bench for rf_wb_arbiter (NUM_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        wb_stall;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        reg_write;
    logic [4:0]  rs3_adds;
    logic [31:0] w_data;
    logic [31:0] pend_mask;

    rf_wb_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .wb_stall  (wb_stall),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .reg_write (reg_write),
        .rs3_adds  (rs3_adds),
        .w_data    (w_data),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          chk_addr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pend;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pend = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each step: drive inputs, check the grant before the edge, and queue the
    // register-file state expected after the edge.
    task automatic step(input bit r, input bit [1:0] v,
                        input bit [4:0] rd0, input logic [31:0] d0,
                        input bit [4:0] rd1, input logic [31:0] d1,
                        input bit st, input bit rv, input bit [4:0] rrd,
                        input int g, input string tag);
        exp_t        e;
        logic [1:0]  exp_rdy;
        logic [4:0]  rd_g;
        logic [31:0] d_g;
        rst       = r;
        req_valid = v;
        req_rd    = {5'd0, rd1, rd0} [9:0];
        req_data  = {d1, d0};
        wb_stall  = st;
        rsv_valid = rv;
        rsv_rd    = rrd;
        @(negedge clk);
        exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
        check({tag, " ready"}, {30'b0, req_ready}, {30'b0, exp_rdy});
        rd_g = (g == 1) ? rd1 : rd0;
        d_g  = (g == 1) ? d1 : d0;
        e.we       = !r && (g >= 0) && (rd_g != 5'd0);
        e.chk_addr = r || e.we;
        e.rd       = r ? 5'd0 : rd_g;
        e.data     = r ? 32'd0 : d_g;
        if (r) begin
            exp_pend = '0;
        end else begin
            if (g >= 0) exp_pend[rd_g] = 1'b0;
            if (rv && rrd != 5'd0) exp_pend[rrd] = 1'b1;
            exp_pend[0] = 1'b0;
        end
        e.pend = exp_pend;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd0, -1, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("reg_write", {31'b0, reg_write}, {31'b0, e.we});
                check("pend_mask", pend_mask, e.pend);
                if (e.chk_addr) begin
                    check("rs3_adds", {27'b0, rs3_adds}, {27'b0, e.rd});
                    check("w_data", w_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int g;
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        wb_stall = 1'b0; rsv_valid = 1'b0; rsv_rd = '0;
        @(posedge clk);
        #1;
        step(1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd0, -1, "reset0");
        step(1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd0, -1, "reset1");

        step(0, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 0, 0, 5'd0, 0, "single");
        idle("single_after");
        idle("idle");

        step(1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd0, -1, "reset_arb");
        for (int i = 0; i < 4; i++) begin
`ifdef RF_WB_RR_ARB_EN
            g = i % 2;
`else
            g = 0;
`endif
            step(0, 2'b11, 5'd1, 32'h1111_0001, 5'd2, 32'h2222_0002, 0, 0, 5'd0, g, "both");
        end
        idle("both_after");

        step(0, 2'b10, 5'd0, 32'd0, 5'd0, 32'h0000_0001, 0, 0, 5'd0, 1, "rd_zero");
        idle("rd_zero_after");

        step(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 5'd7, -1, "rsv7");
        check("pend7_set", {31'b0, pend_mask[7]}, 32'd1);
        step(0, 2'b01, 5'd7, 32'h7777_0007, 5'd0, 32'd0, 0, 1, 5'd7, 0, "rsv7_xfer");
        check("pend7_set_wins", {31'b0, pend_mask[7]}, 32'd1);
        step(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 5'd9, -1, "rsv9");
        check("pend9_set", {31'b0, pend_mask[9]}, 32'd1);
        step(0, 2'b01, 5'd9, 32'h9999_0009, 5'd0, 32'd0, 0, 0, 5'd0, 0, "xfer9");
        check("pend9_clr", {31'b0, pend_mask[9]}, 32'd0);
        step(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 5'd0, -1, "rsv_x0");
        check("pend0_zero", {31'b0, pend_mask[0]}, 32'd0);

        step(0, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0, 1, 1, 5'd3, -1, "stall0");
        step(0, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0, 1, 0, 5'd0, -1, "stall1");
        step(0, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0, 1, 0, 5'd0, -1, "stall2");
        check("pend3_frozen", {31'b0, pend_mask[3]}, 32'd1);
        step(0, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0, 0, 0, 5'd0, 0, "unstall");
        idle("unstall_after");

        step(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 5'd20, -1, "rsv20");
        step(0, 2'b01, 5'd12, 32'hC0DE_000C, 5'd0, 32'd0, 0, 0, 5'd0, 0, "pre_rst");
        step(1, 2'b01, 5'd12, 32'hC0DE_000C, 5'd0, 32'd0, 0, 0, 5'd0, -1, "rst_mid");
        step(0, 2'b01, 5'd12, 32'hC0DE_000C, 5'd0, 32'd0, 0, 0, 5'd0, 0, "after_rst");
        idle("end0");
        idle("end1");

        repeat (2) @(posedge clk);
        #3;
        check("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
